hazard_ctrl: RTL and testbench

Parametrised pipeline hazard controller for the 5-stage ARM core (F/D/E/M/WB). It sits beside the datapath and provides:
- E-stage operand forwarding from M and WB;
- load-use stalls;
- branch/PC-write flushes;
- a registered multicycle-execute sequencer that freezes F/D/E for a configurable latency and injects bubbles into M.

It supersedes the single-cycle combinational hazard logic with parametrised register-address width and multicycle-op support.

---
 rtl/hazard_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_hazard_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl -- pipeline hazard controller for the 5-stage (F/D/E/M/WB) core.
//
// Purpose:
//   * E-stage operand forwarding from M (priority) and WB.
//   * Load-use stall detection.
//   * Branch / PC-write flushes.
//   * Multicycle-execute sequencer: once a multicycle op starts in E, F/D/E
//     are frozen for MUL_LAT-1 further cycles while M receives bubbles.
//
// Parameters:
//   REG_AW  register address width
//   MUL_LAT total E-stage cycles of a multicycle op (>= 1)
//   CNT_W   width of the optional performance counters
//
// Ports:
//   clk, reset                       clock, synchronous active-high reset
//   ra1D, ra2D                       source registers in D
//   ra1E, ra2E                       source registers in E
//   wa3E, wa3M, wa3WB                destination registers in E/M/WB
//   RegWriteM, RegWriteWB            destination write enables in M/WB
//   MemtoRegE                        E holds a load
//   PCSrcD/E/M/WB                    PC-writing instruction in that stage
//   BranchTakenE                     branch resolved taken in E
//   MulStartE                        first cycle of a multicycle op in E
//   forwardaE, forwardbE             00 regfile, 01 WB result, 10 M result
//   StallF/D/E                       hold stage register
//   FlushD/E/M                       clear stage register to a bubble
//   busy                             multicycle sequencer active
//   stall_cnt, flush_cnt             perf counters (HAZARD_PERF_CNT_EN only)
//
// Optional feature macro: HAZARD_PERF_CNT_EN (adds saturating counters).
//
// Stall and flush may both be asserted for the same stage register; the
// stage register is expected to give the clear priority over the hold.
// ---------------------------------------------------------------------------
module hazard_ctrl #(
  parameter int REG_AW  = 4,
  parameter int MUL_LAT = 3,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] ra1D,
  input  logic [REG_AW-1:0] ra2D,
  input  logic [REG_AW-1:0] ra1E,
  input  logic [REG_AW-1:0] ra2E,
  input  logic [REG_AW-1:0] wa3E,
  input  logic [REG_AW-1:0] wa3M,
  input  logic [REG_AW-1:0] wa3WB,
  input  logic              RegWriteM,
  input  logic              RegWriteWB,
  input  logic              MemtoRegE,
  input  logic              PCSrcD,
  input  logic              PCSrcE,
  input  logic              PCSrcM,
  input  logic              PCSrcWB,
  input  logic              BranchTakenE,
  input  logic              MulStartE,
  output logic [1:0]        forwardaE,
  output logic [1:0]        forwardbE,
  output logic              StallF,
  output logic              StallD,
  output logic              StallE,
  output logic              FlushD,
  output logic              FlushE,
  output logic              FlushM,
  output logic              busy
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
`endif
);

  // Elaboration-time parameter sanity check.
  generate
    if (MUL_LAT < 1 || CNT_W < 1) begin : g_bad_param
      $error("hazard_ctrl: MUL_LAT and CNT_W must both be >= 1");
    end
  endgenerate

  localparam int CW = $clog2(MUL_LAT) + 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(MUL_LAT - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  // Single-cycle configuration: the sequencer can never be entered.
  localparam logic MULTI_EN = (MUL_LAT > 1);

  typedef enum logic {S_IDLE, S_BUSY} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  // Forwarding: M stage holds the younger result, so it wins over WB.
  function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] ra);
    if (RegWriteM && (ra == wa3M))        return 2'b10;
    else if (RegWriteWB && (ra == wa3WB)) return 2'b01;
    else                                  return 2'b00;
  endfunction

  assign forwardaE = fwd_sel(ra1E);
  assign forwardbE = fwd_sel(ra2E);

  logic ldr_stall;
  logic pc_wr_pending;

  assign ldr_stall     = MemtoRegE && ((ra1D == wa3E) || (ra2D == wa3E));
  assign pc_wr_pending = PCSrcD || PCSrcE || PCSrcM;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    StallF  = 1'b0;
    StallD  = 1'b0;
    StallE  = 1'b0;
    FlushD  = 1'b0;
    FlushE  = 1'b0;
    FlushM  = 1'b0;
    busy    = 1'b0;
    case (state_q)
      S_IDLE: begin
        StallF = ldr_stall || pc_wr_pending;
        StallD = ldr_stall;
        FlushD = pc_wr_pending || PCSrcWB || BranchTakenE;
        FlushE = ldr_stall || BranchTakenE;
        // A taken branch kills the op in E, so it must not start the sequencer.
        if (MulStartE && !BranchTakenE && MULTI_EN) begin
          state_d = S_BUSY;
          cnt_d   = CNT_LOAD;
        end
      end
      S_BUSY: begin
        // E holds the multicycle op; everything upstream freezes and M
        // gets a bubble every held cycle. Only a retiring PC write in WB
        // may still squash D.
        busy   = 1'b1;
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        FlushM = 1'b1;
        FlushD = PCSrcWB;
        if (cnt_q == CNT_ONE) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;

  // Both counters saturate rather than wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (StallF && (stall_cnt_q != '1))
        stall_cnt_q <= stall_cnt_q + 1'b1;
      if ((FlushD || FlushE || FlushM) && (flush_cnt_q != '1))
        flush_cnt_q <= flush_cnt_q + 1'b1;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

  localparam int AW      = 4;
  localparam int LAT     = 3;
  localparam int CW_PERF = 4;
  localparam int SAT     = (1 << CW_PERF) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] ra1D, ra2D, ra1E, ra2E, wa3E, wa3M, wa3WB;
  logic          RegWriteM, RegWriteWB, MemtoRegE;
  logic          PCSrcD, PCSrcE, PCSrcM, PCSrcWB, BranchTakenE, MulStartE;
  logic [1:0]    forwardaE, forwardbE;
  logic          StallF, StallD, StallE, FlushD, FlushE, FlushM, busy;
`ifdef HAZARD_PERF_CNT_EN
  logic [CW_PERF-1:0] stall_cnt, flush_cnt;
`endif

  always #5 clk = ~clk;

  hazard_ctrl #(.REG_AW(AW), .MUL_LAT(LAT), .CNT_W(CW_PERF)) dut (
    .clk(clk), .reset(reset),
    .ra1D(ra1D), .ra2D(ra2D), .ra1E(ra1E), .ra2E(ra2E),
    .wa3E(wa3E), .wa3M(wa3M), .wa3WB(wa3WB),
    .RegWriteM(RegWriteM), .RegWriteWB(RegWriteWB), .MemtoRegE(MemtoRegE),
    .PCSrcD(PCSrcD), .PCSrcE(PCSrcE), .PCSrcM(PCSrcM), .PCSrcWB(PCSrcWB),
    .BranchTakenE(BranchTakenE), .MulStartE(MulStartE),
    .forwardaE(forwardaE), .forwardbE(forwardbE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE),
    .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM), .busy(busy)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: number of frozen cycles still owed to the multicycle
  // op in E, plus the two event counts.
  int busy_left = 0;
  int m_stall   = 0;
  int m_flush   = 0;

  // Expected outputs for the current inputs.
  logic [1:0] e_fa, e_fb;
  logic e_sf, e_sd, e_se, e_fd, e_fe, e_fm, e_busy;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] ref_fwd(input int ra);
    if (RegWriteM && ra == int'(wa3M))   return 2'd2;
    if (RegWriteWB && ra == int'(wa3WB)) return 2'd1;
    return 2'd0;
  endfunction

  task automatic compute_expected();
    bit ldr, pcw;
    ldr = MemtoRegE && (ra1D == wa3E || ra2D == wa3E);
    pcw = PCSrcD || PCSrcE || PCSrcM;
    e_fa   = ref_fwd(int'(ra1E));
    e_fb   = ref_fwd(int'(ra2E));
    e_busy = (busy_left > 0);
    if (e_busy) begin
      e_sf = 1; e_sd = 1; e_se = 1; e_fm = 1; e_fe = 0; e_fd = PCSrcWB;
    end else begin
      e_sf = ldr || pcw; e_sd = ldr; e_se = 0;
      e_fd = pcw || PCSrcWB || BranchTakenE;
      e_fe = ldr || BranchTakenE; e_fm = 0;
    end
  endtask

  task automatic check_all(input int step_no);
    compute_expected();
    chk("forwardaE", 16'(forwardaE), 16'(e_fa));
    chk("forwardbE", 16'(forwardbE), 16'(e_fb));
    chk("StallF",    16'(StallF),    16'(e_sf));
    chk("StallD",    16'(StallD),    16'(e_sd));
    chk("StallE",    16'(StallE),    16'(e_se));
    chk("FlushD",    16'(FlushD),    16'(e_fd));
    chk("FlushE",    16'(FlushE),    16'(e_fe));
    chk("FlushM",    16'(FlushM),    16'(e_fm));
    chk("busy",      16'(busy),      16'(e_busy));
`ifdef HAZARD_PERF_CNT_EN
    chk("stall_cnt", 16'(stall_cnt), 16'(m_stall));
    chk("flush_cnt", 16'(flush_cnt), 16'(m_flush));
`endif
    $display("step %0d rst=%0b mul=%0b br=%0b busy=%0b fa=%0d fb=%0d S=%0b%0b%0b F=%0b%0b%0b",
             step_no, reset, MulStartE, BranchTakenE, busy, forwardaE, forwardbE,
             StallF, StallD, StallE, FlushD, FlushE, FlushM);
  endtask

  // Advance the model across one rising edge using the inputs now applied.
  task automatic model_edge();
    if (reset) begin
      busy_left = 0; m_stall = 0; m_flush = 0;
    end else begin
      if (e_sf && m_stall < SAT) m_stall++;
      if ((e_fd || e_fe || e_fm) && m_flush < SAT) m_flush++;
      if (busy_left > 0)                                  busy_left--;
      else if (MulStartE && !BranchTakenE && LAT > 1)     busy_left = LAT - 1;
    end
  endtask

  int step_no = 0;

  // Inputs are applied at posedge+1; check at posedge+3; then take the edge.
  task automatic step();
    #2;
    check_all(step_no);
    step_no++;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic clr();
    reset = 0; ra1D = 0; ra2D = 0; ra1E = 0; ra2E = 0;
    wa3E = 4'hF; wa3M = 4'hE; wa3WB = 4'hD;
    RegWriteM = 0; RegWriteWB = 0; MemtoRegE = 0;
    PCSrcD = 0; PCSrcE = 0; PCSrcM = 0; PCSrcWB = 0;
    BranchTakenE = 0; MulStartE = 0;
  endtask

  initial begin
    clr();
    reset = 1;
    @(posedge clk); #1;
    busy_left = 0; m_stall = 0; m_flush = 0;
    // Reset state
    step();
    reset = 0;
    step();

    // Forwarding priority
    ra1E = 3; wa3M = 3; RegWriteM = 1; wa3WB = 3; RegWriteWB = 1; ra2E = 3;
    step();
    RegWriteM = 0;
    step();
    RegWriteWB = 0;
    step();
    clr();

    // Load-use stall for one cycle
    MemtoRegE = 1; wa3E = 5; ra2D = 5;
    step();
    clr();
    step();

    // Multicycle op: start, two BUSY cycles, back to IDLE
    MulStartE = 1;
    step();
    MulStartE = 0; PCSrcWB = 1; BranchTakenE = 1; MemtoRegE = 1; wa3E = 0;
    step();
    clr(); MulStartE = 1;   // ignored while BUSY
    step();
    MulStartE = 0;
    step();
    step();

    // Branch wins over multicycle start
    MulStartE = 1; BranchTakenE = 1;
    step();
    clr();
    step();

    // Reset in the first BUSY cycle
    MulStartE = 1;
    step();
    clr(); reset = 1;
    step();
    reset = 0;
    step();

    // Stall held for 20 cycles (counter saturation when counters present)
    PCSrcD = 1;
    repeat (20) step();
    clr();
    step();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      reset        = ($urandom_range(0, 39) == 0);
      ra1D         = AW'($urandom_range(0, 3));
      ra2D         = AW'($urandom_range(0, 3));
      ra1E         = AW'($urandom_range(0, 3));
      ra2E         = AW'($urandom_range(0, 3));
      wa3E         = AW'($urandom_range(0, 3));
      wa3M         = AW'($urandom_range(0, 3));
      wa3WB        = AW'($urandom_range(0, 3));
      RegWriteM    = 1'($urandom_range(0, 1));
      RegWriteWB   = 1'($urandom_range(0, 1));
      MemtoRegE    = ($urandom_range(0, 3) == 0);
      PCSrcD       = ($urandom_range(0, 7) == 0);
      PCSrcE       = ($urandom_range(0, 7) == 0);
      PCSrcM       = ($urandom_range(0, 7) == 0);
      PCSrcWB      = ($urandom_range(0, 5) == 0);
      BranchTakenE = ($urandom_range(0, 5) == 0);
      MulStartE    = ($urandom_range(0, 3) == 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
